// File: rtl/bcd_multidigit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_multidigit_counter                                       |
// | Description : Parametrised N-digit BCD up/down counter with enable,        |
// |               validated synchronous load, terminal count, wrap pulse,      |
// |               load-error pulse and sticky overflow flag.                   |
// |               Optional macro BCD_CNT_SATURATE_EN: boundary steps saturate  |
// |               instead of wrapping (wrap/overflow still report them).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_multidigit_counter #(
    parameter int                  DIGITS     = 4,
    parameter logic [4*DIGITS-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  clear_flag,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err,
    output logic                  overflow
);

`ifdef BCD_CNT_SATURATE_EN
    localparam logic c_saturate = 1'b1;
`else
    localparam logic c_saturate = 1'b0;
`endif

    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic                r_load_err;
    logic                r_overflow;

    logic [DIGITS-1:0]   w_is9;
    logic [DIGITS-1:0]   w_is0;
    logic [DIGITS-1:0]   w_nib_ok;
    logic                w_load_ok;
    logic                w_boundary;
    logic [4*DIGITS-1:0] w_count_step;
    logic [4*DIGITS-1:0] w_count_next;
    logic                w_carry;
    logic [3:0]          w_dig;

    // Per-digit status flags for the current count and the load data.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_is9[gi]    = (r_count[4*gi +: 4] == 4'd9);
            assign w_is0[gi]    = (r_count[4*gi +: 4] == 4'd0);
            assign w_nib_ok[gi] = (load_value[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    assign w_load_ok  = &w_nib_ok;
    assign w_boundary = up_down ? (&w_is9) : (&w_is0);
    assign tc         = en & w_boundary;

    // Ripple the carry/borrow through the digits: a digit steps only when all
    // lower digits sit at their rollover value (9 going up, 0 going down).
    always_comb begin
        w_count_step = r_count;
        w_carry      = 1'b1;
        w_dig        = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_count[4*i +: 4];
            if (w_carry) begin
                if (up_down) begin
                    w_count_step[4*i +: 4] = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
                end else begin
                    w_count_step[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
                end
            end
            w_carry = w_carry & (up_down ? (w_dig == 4'd9) : (w_dig == 4'd0));
        end
    end

    // In saturating builds a boundary step is blocked and the count holds.
    assign w_count_next = (c_saturate && w_boundary) ? r_count : w_count_step;

    // State update: load has priority over counting; pulses default low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= INIT_VALUE;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_count <= load_value;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (en) begin
                r_count <= w_count_next;
                r_wrap  <= w_boundary;
            end
            // Set beats clear when both happen in the same cycle.
            if (!load && en && w_boundary) begin
                r_overflow <= 1'b1;
            end else if (clear_flag) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
